// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rowsw_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu9t5v0__rowsw_seq_if
// Brief    : Request/ack bundle between power management and the row sequencer.
// Revision : 1.0
// ============================================================================
interface gf180mcu_fd_sc_mcu9t5v0__rowsw_seq_if #(
  parameter int NUM_ROWS = 8,
  parameter int DLY_W    = 8
);
  logic                PWR_REQ;
  logic [DLY_W-1:0]    DLY;
  logic [NUM_ROWS-1:0] ROW_EN;
  logic                PWR_ACK;
  logic                BUSY;

  modport master (
    output PWR_REQ,
    output DLY,
    input  ROW_EN,
    input  PWR_ACK,
    input  BUSY
  );

  modport slave (
    input  PWR_REQ,
    input  DLY,
    output ROW_EN,
    output PWR_ACK,
    output BUSY
  );
endinterface
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rowsw_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu9t5v0__rowsw_seq
// Brief    : Staggered power-up/down sequencer for switched fill/decap rows.
// Revision : 1.0
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__rowsw_seq #(
  parameter int NUM_ROWS = 8,
  parameter int DLY_W    = 8
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu9t5v0__rowsw_seq_if.slave bus
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_ON   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DLY_W-1:0]    cnt_q, cnt_d;
  logic [NUM_ROWS-1:0] row_en_q, row_en_d;
  logic                ack_q, ack_d;

  logic all_on;
  logic cnt_zero;

  assign all_on   = &row_en_q;
  assign cnt_zero = (cnt_q == '0);

  // Rows stay thermometer-coded: growing shifts a one in at bit 0,
  // shrinking shifts the top one out.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_en_d = row_en_q;
    ack_d    = ack_q;
    case (state_q)
      ST_OFF: begin
        if (bus.PWR_REQ) begin
          row_en_d = row_en_q | NUM_ROWS'(1);
          cnt_d    = bus.DLY;
          state_d  = ST_UP;
        end
      end
      ST_UP: begin
        if (!bus.PWR_REQ) begin
          state_d = ST_DOWN;
          cnt_d   = bus.DLY;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else if (all_on) begin
          state_d = ST_ON;
          ack_d   = 1'b1;
        end else begin
          row_en_d = (row_en_q << 1) | NUM_ROWS'(1);
          cnt_d    = bus.DLY;
        end
      end
      ST_ON: begin
        if (!bus.PWR_REQ) begin
          ack_d    = 1'b0;
          row_en_d = row_en_q >> 1;
          cnt_d    = bus.DLY;
          state_d  = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (bus.PWR_REQ) begin
          state_d = ST_UP;
          cnt_d   = bus.DLY;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else if (row_en_q == '0) begin
          state_d = ST_OFF;
        end else begin
          row_en_d = row_en_q >> 1;
          cnt_d    = bus.DLY;
        end
      end
      default: begin
        state_d  = ST_OFF;
        row_en_d = '0;
        ack_d    = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      row_en_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_en_q <= row_en_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.ROW_EN  = row_en_q;
  assign bus.PWR_ACK = ack_q;
  assign bus.BUSY    = (state_q == ST_UP) || (state_q == ST_DOWN);

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rowsw_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu9t5v0__rowsw_seq
// Brief    : Directed and randomised checks of the row-switch sequencer.
// Revision : 1.0
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__rowsw_seq;

  localparam int N  = 4;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__rowsw_seq_if #(.NUM_ROWS(N), .DLY_W(DW)) bus ();

  gf180mcu_fd_sc_mcu9t5v0__rowsw_seq #(.NUM_ROWS(N), .DLY_W(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: number of rows lit, remaining wait, ramp direction
  // (+1 up, -1 down, 0 settled) and whether a full ramp has completed.
  int m_lvl = 0;
  int m_wt  = 0;
  int m_dir = 0;
  bit m_ack = 1'b0;
  logic [N-1:0] prev_row = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit rst, input bit req, input int d);
    if (rst) begin
      m_lvl = 0; m_wt = 0; m_dir = 0; m_ack = 1'b0;
    end else if (m_ack) begin
      if (!req) begin
        m_ack = 1'b0; m_lvl = N - 1; m_wt = d; m_dir = -1;
      end
    end else if (m_dir == 0) begin
      if (req) begin
        m_lvl = 1; m_wt = d; m_dir = 1;
      end
    end else if (m_dir == 1) begin
      if (!req) begin
        m_dir = -1; m_wt = d;
      end else if (m_wt > 0) m_wt--;
      else if (m_lvl == N) begin
        m_dir = 0; m_ack = 1'b1;
      end else begin
        m_lvl++; m_wt = d;
      end
    end else begin
      if (req) begin
        m_dir = 1; m_wt = d;
      end else if (m_wt > 0) m_wt--;
      else if (m_lvl == 0) m_dir = 0;
      else begin
        m_lvl--; m_wt = d;
      end
    end
  endfunction

  task automatic tick();
    bit r;
    bit req;
    int d;
    logic [N-1:0] row;
    logic [N-1:0] nxt;
    r   = RST;
    req = bus.PWR_REQ;
    d   = int'(bus.DLY);
    @(posedge CLK);
    model_step(r, req, d);
    #1;
    row = bus.ROW_EN;
    nxt = row + 1'b1;
    chk("row_en", 32'(row), 32'((1 << m_lvl) - 1));
    chk("pwr_ack", 32'(bus.PWR_ACK), 32'(m_ack));
    chk("busy", 32'(bus.BUSY), 32'(m_dir != 0));
    chk("thermometer", 32'((row & nxt) == '0), 32'd1);
    if (!r) chk("one_bit_step", 32'($countones(row ^ prev_row) <= 1), 32'd1);
    chk("ack_all_on", 32'(!bus.PWR_ACK || (row == '1)), 32'd1);
    prev_row = row;
  endtask

  initial begin
    RST = 1'b1;
    bus.PWR_REQ = 1'b0;
    bus.DLY = 8'd2;
    tick();
    tick();
    chk("rst_row", 32'(bus.ROW_EN), 32'h0);
    chk("rst_ack", 32'(bus.PWR_ACK), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);

    // power-up, DLY=2
    RST = 1'b0;
    bus.PWR_REQ = 1'b1;
    tick();
    chk("up_k", 32'(bus.ROW_EN), 32'h1);
    chk("up_k_busy", 32'(bus.BUSY), 32'h1);
    repeat (3) tick();
    chk("up_k3", 32'(bus.ROW_EN), 32'h3);
    repeat (3) tick();
    chk("up_k6", 32'(bus.ROW_EN), 32'h7);
    repeat (3) tick();
    chk("up_k9", 32'(bus.ROW_EN), 32'hF);
    chk("up_k9_ack", 32'(bus.PWR_ACK), 32'h0);
    repeat (2) tick();
    chk("up_k11_busy", 32'(bus.BUSY), 32'h1);
    tick();
    chk("up_k12_ack", 32'(bus.PWR_ACK), 32'h1);
    chk("up_k12_busy", 32'(bus.BUSY), 32'h0);

    // power-down from ON, DLY=2
    repeat (2) tick();
    bus.PWR_REQ = 1'b0;
    tick();
    chk("dn_j_ack", 32'(bus.PWR_ACK), 32'h0);
    chk("dn_j", 32'(bus.ROW_EN), 32'h7);
    repeat (3) tick();
    chk("dn_j3", 32'(bus.ROW_EN), 32'h3);
    repeat (3) tick();
    chk("dn_j6", 32'(bus.ROW_EN), 32'h1);
    repeat (3) tick();
    chk("dn_j9", 32'(bus.ROW_EN), 32'h0);
    chk("dn_j9_busy", 32'(bus.BUSY), 32'h1);
    repeat (3) tick();
    chk("dn_j12_busy", 32'(bus.BUSY), 32'h0);

    // DLY=0: one row per edge
    bus.DLY = 8'd0;
    bus.PWR_REQ = 1'b1;
    tick(); chk("z_0", 32'(bus.ROW_EN), 32'h1);
    tick(); chk("z_1", 32'(bus.ROW_EN), 32'h3);
    tick(); chk("z_2", 32'(bus.ROW_EN), 32'h7);
    tick(); chk("z_3", 32'(bus.ROW_EN), 32'hF);
    chk("z_3_ack", 32'(bus.PWR_ACK), 32'h0);
    tick(); chk("z_4_ack", 32'(bus.PWR_ACK), 32'h1);
    bus.PWR_REQ = 1'b0;
    repeat (6) tick();
    chk("z_off_row", 32'(bus.ROW_EN), 32'h0);
    chk("z_off_busy", 32'(bus.BUSY), 32'h0);

    // reversal mid-ramp, DLY=3
    bus.DLY = 8'd3;
    bus.PWR_REQ = 1'b1;
    tick();
    chk("rv_k", 32'(bus.ROW_EN), 32'h1);
    repeat (4) tick();
    chk("rv_k4", 32'(bus.ROW_EN), 32'h3);
    bus.PWR_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rv_hold", 32'(bus.ROW_EN), 32'h3);
      chk("rv_noack", 32'(bus.PWR_ACK), 32'h0);
    end
    tick();
    chk("rv_k9", 32'(bus.ROW_EN), 32'h1);
    repeat (4) tick();
    chk("rv_k13", 32'(bus.ROW_EN), 32'h0);
    repeat (4) tick();
    chk("rv_off_busy", 32'(bus.BUSY), 32'h0);

    // reset mid-ramp, then restart
    bus.DLY = 8'd1;
    bus.PWR_REQ = 1'b1;
    repeat (5) tick();
    chk("mr_pre", 32'(bus.ROW_EN), 32'h7);
    RST = 1'b1;
    tick();
    chk("mr_row", 32'(bus.ROW_EN), 32'h0);
    chk("mr_ack", 32'(bus.PWR_ACK), 32'h0);
    chk("mr_busy", 32'(bus.BUSY), 32'h0);
    RST = 1'b0;
    tick();
    chk("mr_restart", 32'(bus.ROW_EN), 32'h1);

    // randomised request/delay traffic
    for (int i = 0; i < 10000; i++) begin
      if ($urandom % 30 == 0) bus.PWR_REQ = ~bus.PWR_REQ;
      bus.DLY = 8'($urandom_range(0, 3));
      RST = ($urandom % 500 == 0);
      tick();
    end
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__rowsw_seq.md
Name: gf180mcu_fd_sc_mcu9t5v0__rowsw_seq

Overview:
Behavioural model of a staggered power-up/power-down sequencer for switchable fill/decap cell rows.
- Enables N row-switch controls one at a time, each separated by a programmable delay, to bound inrush current on VDD.
- Acknowledges the requester once every row is on, and tears the rows down in reverse order.
- Sits between the always-on power-management logic and the switched fill/decap rows.

Parameters:
NUM_ROWS, 8, number of switched rows (≥1)
DLY_W, 8, width of inter-step delay field

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous active-high reset
VDD  inout  1  power (present only under USE_POWER_PINS)
VSS  inout  1  ground (present only under USE_POWER_PINS)
PWR_REQ  input  1  level request: 1 = rows on, 0 = rows off
DLY  input  DLY_W  extra wait cycles between steps; sampled at each step
ROW_EN  output  NUM_ROWS  row switch enables; bit 0 switched first on power-up
PWR_ACK  output  1  registered; 1 only while all rows are on and stable
BUSY  output  1  1 while ramping (state UP or DOWN); decoded from the state register

Behaviour:
- Reset: synchronous, RST=1 sampled at an edge gives state=OFF, ROW_EN=0, PWR_ACK=0, cnt=0. It overrides all else, including mid-ramp: rows drop at once.
- States: OFF, UP, DOWN, ON. Internal down-counter cnt of width DLY_W.
- OFF:
  - PWR_REQ=1 at edge: ROW_EN[0]<=1, cnt<=DLY, go to UP.
  - Otherwise hold.
- UP, priority order at each edge:
  - (a) PWR_REQ=0: go to DOWN, cnt<=DLY, ROW_EN unchanged that edge.
  - (b) cnt!=0: cnt--.
  - (c) all rows on: go to ON, PWR_ACK<=1.
  - (d) otherwise set the lowest clear bit of ROW_EN, cnt<=DLY.
- ON:
  - PWR_REQ=0 at edge: PWR_ACK<=0, clear ROW_EN[NUM_ROWS-1], cnt<=DLY, go to DOWN.
  - Otherwise hold.
- DOWN, priority order at each edge:
  - (a) PWR_REQ=1: go to UP, cnt<=DLY, ROW_EN unchanged.
  - (b) cnt!=0: cnt--.
  - (c) ROW_EN==0: go to OFF.
  - (d) otherwise clear the highest set bit, cnt<=DLY.
- Invariant: ROW_EN is always thermometer-coded (contiguous ones from bit 0). It never changes by more than one bit per edge.
- Timing:
  - REQ seen in OFF at edge k, delay d: row i is enabled at edge k+i(d+1); PWR_ACK=1 at edge k+NUM_ROWS(d+1).
  - Power-down from ON is symmetric; OFF is reached (d+1) cycles after the last row clears.
- DLY=0: one row per cycle.
- DLY changes mid-ramp take effect at the next cnt reload only.
- Direction reversal mid-ramp resumes from the current ROW_EN. PWR_ACK stays 0 until a complete UP sequence finishes.
- PWR_REQ pulse of 1 cycle in OFF: row 0 turns on, the next edge reverses, and the sequence returns to OFF normally.
- NUM_ROWS=1 is legal; behaves as a single delayed enable.

Test Plan:
- NUM_ROWS=4, DLY=2, RST then PWR_REQ=1 seen at edge k -> ROW_EN 0001@k, 0011@k+3, 0111@k+6, 1111@k+9; PWR_ACK=1@k+12; BUSY=1 from k to k+11.
- From ON, PWR_REQ=0 seen at edge j, DLY=2 -> PWR_ACK=0@j, ROW_EN 0111@j, 0011@j+3, 0001@j+6, 0000@j+9; state OFF, BUSY=0@j+12.
- DLY=0, NUM_ROWS=4 -> one new bit per edge; PWR_ACK 4 edges after the first enable.
- Reversal: DLY=3, drop PWR_REQ when ROW_EN=0011 -> ROW_EN holds 0011 for 4 cycles, then 0001, then 0000; PWR_ACK never asserts.
- RST=1 asserted while ROW_EN=0111 in UP -> next edge ROW_EN=0, PWR_ACK=0, BUSY=0. With PWR_REQ still 1 after RST drops -> restart from 0001.
- Randomised PWR_REQ/DLY for 10k cycles -> ROW_EN always thermometer-coded, at most one bit change per edge, PWR_ACK implies ROW_EN all ones.
